// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcode/func constants, instruction field positions
// and the fetch-unit state encoding.
package cpu_defs_pkg;

  // Instruction word width
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMM_W   = 16;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  // Instruction field bit positions
  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 26;
  localparam int unsigned RS_MSB   = 25;
  localparam int unsigned RS_LSB   = 21;
  localparam int unsigned RT_MSB   = 20;
  localparam int unsigned RT_LSB   = 16;
  localparam int unsigned RD_MSB   = 15;
  localparam int unsigned RD_LSB   = 11;
  localparam int unsigned FN_MSB   = 5;
  localparam int unsigned FN_LSB   = 0;
  localparam int unsigned IMM_MSB  = 15;
  localparam int unsigned IMM_LSB  = 0;

  // Fetch state encoding
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StIssue = 2'd2,
    StHalt  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: sequential pc+4 and the taken-branch target
// pc+4+(sext(imm16)<<2). Purely combinational, all math modulo 2^ADDR_W.
module pc_next_calc
  import cpu_defs_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [IMM_W-1:0]  imm16,
  input  logic              branch_taken,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] br_off;

  // Sign-extend the word offset to a byte offset and select the successor PC
  always_comb begin
    br_off   = {{(ADDR_W - IMM_W - 2){imm16[IMM_W-1]}}, imm16, 2'b00};
    pc_plus4 = pc + ADDR_W'(4);
    next_pc  = branch_taken ? (pc_plus4 + br_off) : pc_plus4;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: holds the PC, fetches over a req/valid memory
// handshake, latches the word and presents decoded fields while issuing.
// A fetch that sees no response for TIMEOUT cycles parks the unit in HALT.
module instr_fetch_unit
  import cpu_defs_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  input  logic              stall,
  input  logic              branch_taken,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [5:0]        func,
  output logic [15:0]       imm16,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_err
);

  // TIMEOUT of 1 still needs a one-bit counter
  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  next_pc;

  pc_next_calc #(
    .ADDR_W(ADDR_W)
  ) u_pc_next_calc (
    .pc          (pc_q),
    .imm16       (instr_q[IMM_MSB:IMM_LSB]),
    .branch_taken(branch_taken),
    .pc_plus4    (pc_plus4),
    .next_pc     (next_pc)
  );

  // State, PC, instruction register, timeout counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; memory strobes outside FETCH are deliberately ignored
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          tmo_d   = '0;
          state_d = StIssue;
        end else if (tmo_q == TMO_LAST) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StIssue: begin
        // stall holds everything, including the branch decision
        if (!stall) begin
          pc_d    = next_pc;
          state_d = StFetch;
        end
      end
      StHalt: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decodes of the state register and slices of the registers
  always_comb begin
    imem_req    = (state_q == StFetch);
    imem_addr   = pc_q;
    instr_valid = (state_q == StIssue);
    instr       = instr_q;
    op          = instr_q[OP_MSB:OP_LSB];
    rs          = instr_q[RS_MSB:RS_LSB];
    rt          = instr_q[RT_MSB:RT_LSB];
    rd          = instr_q[RD_MSB:RD_LSB];
    func        = instr_q[FN_MSB:FN_LSB];
    imm16       = instr_q[IMM_MSB:IMM_LSB];
    pc          = pc_q;
    fetch_err   = err_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory/datapath driver feeds words, waits,
// stalls and branch decisions; a reference model tracks the expected PC
// sequence and a monitor compares every fetch address and issued instruction.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0;
  localparam int          TMO    = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        branch_taken;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  func;
  logic [15:0] imm16;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W  (32),
    .RESET_PC(RST_PC),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .stall       (stall),
    .branch_taken(branch_taken),
    .instr_valid (instr_valid),
    .instr       (instr),
    .op          (op),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .func        (func),
    .imm16       (imm16),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    int          flen;  // FETCH cycles the response should take
    int          hold;  // cycles instr_valid should stay high
  } iss_t;

  iss_t        iss_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] prog_q[$];
  int          wait_q[$];
  int          stall_q[$];
  int          br_q[$];

  int          total = 0;
  int          bad = 0;
  bit          expect_err = 1'b0;

  // Driver / model state
  bit          fetching = 1'b0;
  int          wait_left = 0;
  int          fetch_len = 0;
  int          stall_left = 0;
  bit          taken = 1'b0;
  logic [31:0] cur_pc = '0;
  logic [31:0] cur_word = '0;
  logic [31:0] m_pc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not seen (t=%0t)", name, $time);
  endtask

  // Byte offset of a taken branch: signed word count times four
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return 32'(int'($signed(imm)) * 4);
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 2) == 0) w[31:26] = 6'h04;
    return w;
  endfunction

  // One cycle of memory + datapath behaviour, decided at the falling edge
  task automatic step();
    iss_t it;
    @(negedge clk);
    imem_valid   = 1'b0;
    imem_rdata   = $urandom;
    stall        = 1'b0;
    branch_taken = 1'b0;
    if (imem_req) begin
      if (!fetching) begin
        fetching  = 1'b1;
        fetch_len = 0;
        wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : int'($urandom_range(0, 3));
      end
      fetch_len++;
      if (wait_left == 0) begin
        cur_pc     = m_pc;
        cur_word   = (prog_q.size() > 0) ? prog_q.pop_front() : rand_word();
        stall_left = (stall_q.size() > 0) ? stall_q.pop_front() :
                     (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        taken      = (br_q.size() > 0) ? (br_q.pop_front() != 0) : ($urandom_range(0, 1) == 1);
        imem_valid = 1'b1;
        imem_rdata = cur_word;
        it.pc      = cur_pc;
        it.word    = cur_word;
        it.flen    = fetch_len;
        it.hold    = stall_left + 1;
        iss_q.push_back(it);
        fetching   = 1'b0;
      end else begin
        wait_left--;
      end
    end else if (instr_valid) begin
      imem_valid = ($urandom_range(0, 1) == 1);  // stray strobe, must be ignored
      if (stall_left > 0) begin
        stall        = 1'b1;
        branch_taken = ($urandom_range(0, 3) != 0);
        stall_left--;
      end else begin
        branch_taken = taken;
        m_pc = cur_pc + 32'd4 + (taken ? branch_offset(cur_word[15:0]) : 32'd0);
        addr_q.push_back(m_pc);
      end
    end else begin
      imem_valid = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    imem_valid   = 1'b0;
    imem_rdata   = '0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    iss_q.delete();
    addr_q.delete();
    fetching   = 1'b0;
    stall_left = 0;
    fetch_len  = 0;
    expect_err = 1'b0;
    m_pc       = RST_PC;
    addr_q.push_back(RST_PC);
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_pc4", pc_plus4, RST_PC + 32'd4);
    chk("rst_instr", instr, 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_first_req", 32'(imem_req), 32'd1);
  endtask

  // Monitor: pops expectations whenever the DUT starts a fetch or an issue
  initial begin : monitor
    bit          v_prev;
    bit          r_prev;
    int          run;
    int          flen;
    iss_t        cur;
    v_prev = 1'b0;
    r_prev = 1'b0;
    run    = 0;
    flen   = 0;
    cur    = '{pc: '0, word: '0, flen: 0, hold: 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        v_prev = 1'b0;
        r_prev = 1'b0;
        run    = 0;
        flen   = 0;
      end else begin
        if (!expect_err) chk("no_fetch_err", 32'(fetch_err), 32'd0);
        chk("req_valid_excl", 32'(imem_req & instr_valid), 32'd0);
        if (imem_req) begin
          if (!r_prev) begin
            flen = 0;
            if (addr_q.size() == 0) miss("fetch_expected");
            else chk("fetch_addr", imem_addr, addr_q.pop_front());
          end
          flen++;
        end
        if (instr_valid && !v_prev) begin
          if (iss_q.size() == 0) begin
            miss("issue_expected");
          end else begin
            cur = iss_q.pop_front();
            chk("instr", instr, cur.word);
            chk("pc", pc, cur.pc);
            chk("pc_plus4", pc_plus4, cur.pc + 32'd4);
            chk("op", 32'(op), 32'(cur.word[31:26]));
            chk("rs", 32'(rs), 32'(cur.word[25:21]));
            chk("rt", 32'(rt), 32'(cur.word[20:16]));
            chk("rd", 32'(rd), 32'(cur.word[15:11]));
            chk("func", 32'(func), 32'(cur.word[5:0]));
            chk("imm16", 32'(imm16), 32'(cur.word[15:0]));
            chk("fetch_len", 32'(flen), 32'(cur.flen));
          end
          run = 1;
        end else if (instr_valid) begin
          run++;
          chk("hold_instr", instr, cur.word);
          chk("hold_pc", pc, cur.pc);
        end else if (v_prev) begin
          chk("issue_len", 32'(run), 32'(cur.hold));
        end
        v_prev = instr_valid;
        r_prev = imem_req;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit hit;
    rst_n        = 1'b0;
    imem_valid   = 1'b0;
    imem_rdata   = '0;
    stall        = 1'b0;
    branch_taken = 1'b0;

    // Zero-wait stream, branch back to 0x0C, not-taken to 0x14, 3-cycle stall
    prog_q  = '{32'h00221820, 32'h8C430004, 32'h0, 32'h0, 32'h1000FFFE, 32'h0,
                32'h1000FFFE, 32'h0};
    wait_q  = '{0, 0, 0, 0, 0, 0, 0, 0};
    br_q    = '{0, 0, 0, 0, 1, 0, 0, 0};
    stall_q = '{0, 0, 0, 0, 0, 0, 0, 3};
    do_reset();
    repeat (30) step();

    // Branch from 0 to 0xFFFFFFFC, then sequential wrap to 0
    prog_q  = '{32'h1000FFFE, 32'h0, 32'h0};
    wait_q  = '{0, 0, 0};
    br_q    = '{1, 0, 0};
    stall_q = '{0, 0, 0};
    do_reset();
    repeat (12) step();

    repeat (3000) step();

    // Response on the last allowed FETCH cycle, then a fetch that never answers
    wait_q.push_back(TMO - 1);
    wait_q.push_back(1000);
    for (int k = 0; k < 200 && !fetch_err; k++) begin
      step();
      if (wait_q.size() == 0) expect_err = 1'b1;
    end
    chk("timeout_err", 32'(fetch_err), 32'd1);
    chk("timeout_req", 32'(imem_req), 32'd0);
    chk("timeout_fetch_cycles", 32'(fetch_len), 32'(TMO));
    repeat (5) step();
    chk("halt_err_sticky", 32'(fetch_err), 32'd1);
    chk("halt_req", 32'(imem_req), 32'd0);
    chk("halt_valid", 32'(instr_valid), 32'd0);

    // Reset while a fetch is waiting on memory
    do_reset();
    repeat (20) step();
    wait_q.push_back(6);
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      step();
      hit = fetching && (fetch_len >= 2);
    end
    if (!hit) miss("midop_wait");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req_drop", 32'(imem_req), 32'd0);
    chk("async_pc", pc, RST_PC);
    do_reset();
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
